regfile_dump: RTL and testbench

Debug readout engine for the CPU's 4×8-bit general-purpose register file. On a start pulse it takes a consistent snapshot of R0–R3 by sweeping one register-file read port, then transmits a 6-byte frame over a valid/ready byte stream: sync, R0, R1, R2, R3, checksum. It sits beside the register file, shares a read port with the debug/decode path, and feeds the debug serial transmitter.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/regfile_dump.sv | 203 ++++++++++++++++++++
 tb/tb_regfile_dump.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and types used by the register-file debug
// readout engine.
package cpu_pkg;

    // Register file geometry.
    localparam int REG_COUNT  = 4;
    localparam int REG_W      = 8;
    localparam int REG_ADDR_W = 2;

    // Marker byte that opens every debug dump frame.
    localparam logic [7:0] DBG_SYNC_BYTE = 8'hA5;

    // Readout engine states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAPTURE   = 3'd1,
        ST_SEND_SYNC = 3'd2,
        ST_SEND_REG  = 3'd3,
        ST_SEND_SUM  = 3'd4,
        ST_DONE      = 3'd5
    } dump_state_e;

endpackage : cpu_pkg

// File: rtl/regfile_dump.sv
// Debug readout engine: snapshots R0..R(NUM_REGS-1) through one read port,
// then streams a frame of sync, register bytes and an 8-bit additive checksum
// over a valid/ready byte interface.
//
// All outputs come straight from flops. They are loaded from the next-state
// values, so they line up with the state the engine is in during that cycle
// and never depend combinationally on tx_ready.
module regfile_dump
    import cpu_pkg::*;
#(
    parameter int                NUM_REGS  = REG_COUNT,
    parameter int                DATA_W    = REG_W,
    parameter int                ADDR_W    = REG_ADDR_W,
    parameter logic [DATA_W-1:0] SYNC_BYTE = DBG_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    // Checksum accumulate: modulo-2^DATA_W add, carry out is dropped.
    function automatic logic [DATA_W-1:0] csum_add(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] byte_in
    );
        return acc + byte_in;
    endfunction

    dump_state_e       state_r, state_s;
    logic [ADDR_W-1:0] idx_r,   idx_s;
    logic [DATA_W-1:0] sum_r,   sum_s;
    logic [DATA_W-1:0] snap_r [NUM_REGS];
    logic [DATA_W-1:0] snap_s [NUM_REGS];

    logic              busy_r,     busy_s;
    logic              done_r,     done_s;
    logic [ADDR_W-1:0] rd_addr_r,  rd_addr_s;
    logic [DATA_W-1:0] tx_data_r,  tx_data_s;
    logic              tx_valid_r, tx_valid_s;

    logic              accept_s;

    // A byte leaves only when the registered valid meets the downstream ready.
    always_comb begin
        accept_s = tx_valid_r && tx_ready;
    end

    // Next-state logic: capture sweep, frame sequencing and checksum update.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        sum_s   = sum_r;
        snap_s  = snap_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_CAPTURE;
                    idx_s   = '0;
                    sum_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                snap_s[idx_r] = rd_data;
                sum_s         = csum_add(sum_r, rd_data);
                if (idx_r == LAST_IDX) begin
                    state_s = ST_SEND_SYNC;
                    idx_s   = '0;
                end else begin
                    idx_s   = idx_r + IDX_ONE;
                end
            end
            ST_SEND_SYNC: begin
                if (accept_s) begin
                    state_s = ST_SEND_REG;
                    idx_s   = '0;
                end else begin
                    state_s = ST_SEND_SYNC;
                end
            end
            ST_SEND_REG: begin
                if (accept_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_s = ST_SEND_SUM;
                        idx_s   = '0;
                    end else begin
                        idx_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    state_s = ST_SEND_REG;
                end
            end
            ST_SEND_SUM: begin
                if (accept_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SEND_SUM;
                end
            end
            ST_DONE: begin
                // A held start restarts directly so back-to-back frames are
                // separated only by this cycle.
                if (start) begin
                    state_s = ST_CAPTURE;
                    idx_s   = '0;
                    sum_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = '0;
                sum_s   = '0;
            end
        endcase
    end

    // Output decode from the next state so the output flops match the state.
    always_comb begin
        busy_s     = (state_s != ST_IDLE);
        done_s     = (state_s == ST_DONE);
        rd_addr_s  = '0;
        tx_valid_s = 1'b0;
        tx_data_s  = '0;
        case (state_s)
            ST_CAPTURE: begin
                rd_addr_s = idx_s;
            end
            ST_SEND_SYNC: begin
                tx_valid_s = 1'b1;
                tx_data_s  = SYNC_BYTE;
            end
            ST_SEND_REG: begin
                tx_valid_s = 1'b1;
                tx_data_s  = snap_s[idx_s];
            end
            ST_SEND_SUM: begin
                tx_valid_s = 1'b1;
                tx_data_s  = sum_s;
            end
            default: begin
                rd_addr_s  = '0;
                tx_valid_s = 1'b0;
                tx_data_s  = '0;
            end
        endcase
    end

    // Engine state, shared index, snapshot array and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            sum_r   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                snap_r[i] <= '0;
            end
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            sum_r   <= sum_s;
            for (int i = 0; i < NUM_REGS; i++) begin
                snap_r[i] <= snap_s[i];
            end
        end
    end

    // Registered outputs; reset clears them at once, dropping any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_addr_r  <= '0;
            tx_data_r  <= '0;
            tx_valid_r <= 1'b0;
        end else begin
            busy_r     <= busy_s;
            done_r     <= done_s;
            rd_addr_r  <= rd_addr_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign rd_addr  = rd_addr_r;
    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;

endmodule : regfile_dump

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: table of register sets with hand-computed
// checksums, plus sequences for start-while-busy, held start and mid-frame reset.
module tb_regfile_dump;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    logic [7:0] regs [4];

    int n_checks;
    int n_fail;

    typedef struct {
        logic [31:0] regs_pk;   // R_i in bits [8*i +: 8]
        logic [7:0]  exp_sum;
        bit          bp;        // random backpressure
        bit          wr_r2;     // overwrite R2 while sending registers
    } vec_t;

    vec_t vecs [6];

    regfile_dump dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    assign rd_data = regs[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},     {31'd0, busy},     32'd0);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
        chk({tag, "_rd_addr"},  {30'd0, rd_addr},  32'd0);
        chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, "_tx_data"},  {24'd0, tx_data},  32'd0);
    endtask

    // One frame. Called at a negedge; with skip=1 the DUT is already in the
    // first capture cycle. With hold=1 start stays high and the task returns
    // in the first capture cycle of the following frame.
    task automatic run_frame(input logic [31:0] rp, input logic [7:0] es,
                             input bit bp, input bit wr, input bit poke,
                             input bit hold, input bit skip);
        logic [7:0] exp_b [6];
        int         guard;
        bit         acc;
        bit         rdy;
        for (int i = 0; i < 4; i++) begin
            regs[i]      = rp[8*i +: 8];
            exp_b[i + 1] = rp[8*i +: 8];
        end
        exp_b[0] = 8'hA5;
        exp_b[5] = es;
        if (!skip) begin
            start = 1'b1;
            @(negedge clk);
        end
        if (!hold) start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("cap_busy",     {31'd0, busy},     32'd1);
            chk("cap_rd_addr",  {30'd0, rd_addr},  i);
            chk("cap_tx_valid", {31'd0, tx_valid}, 32'd0);
            if (poke && i == 1) start = 1'b1;
            else if (!hold)     start = 1'b0;
            @(negedge clk);
        end
        for (int b = 0; b < 6; b++) begin
            guard = 0;
            acc   = 1'b0;
            while (!acc) begin
                chk("tx_valid", {31'd0, tx_valid}, 32'd1);
                chk("tx_data",  {24'd0, tx_data},  {24'd0, exp_b[b]});
                if (wr && b == 3) regs[2] = 8'h77;
                if (poke && b == 1) start = 1'b1;
                else if (!hold)     start = 1'b0;
                rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (guard >= 8) rdy = 1'b1;
                tx_ready = rdy;
                acc      = rdy;
                @(negedge clk);
                guard++;
            end
        end
        tx_ready = 1'b1;
        chk("done_pulse",    {31'd0, done},     32'd1);
        chk("done_busy",     {31'd0, busy},     32'd1);
        chk("done_tx_valid", {31'd0, tx_valid}, 32'd0);
        @(negedge clk);
        chk("after_done", {31'd0, done}, 32'd0);
        if (hold) begin
            chk("retrigger_busy",    {31'd0, busy},    32'd1);
            chk("retrigger_rd_addr", {30'd0, rd_addr}, 32'd0);
        end else begin
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    // Absolute time limit in case anything stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{32'h44332211, 8'hAA, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 8'hFC, 1'b0, 1'b0};
        vecs[2] = '{32'h04030201, 8'h0A, 1'b1, 1'b0};
        vecs[3] = '{32'h44332211, 8'hAA, 1'b0, 1'b1};
        vecs[4] = '{32'h017F8080, 8'h80, 1'b1, 1'b0};
        vecs[5] = '{32'h00000000, 8'h00, 1'b0, 1'b0};

        rst_n    = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) regs[i] = 8'h00;
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("idle");

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].regs_pk, vecs[v].exp_sum, vecs[v].bp, vecs[v].wr_r2,
                      1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end

        // start pulses while busy: one frame only, then stays idle.
        run_frame(32'h44332211, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_queue_busy",     {31'd0, busy},     32'd0);
            chk("no_queue_tx_valid", {31'd0, tx_valid}, 32'd0);
        end

        // start held high: back-to-back frames separated by the DONE cycle.
        run_frame(32'h04030201, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame(32'h44332211, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        // Reset while presenting R1 (idx=1), stalled by tx_ready low.
        for (int i = 0; i < 4; i++) regs[i] = 8'h11 * (i + 1);
        tx_ready = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_seq_sync", {24'd0, tx_data}, 32'h000000A5);
        @(negedge clk);
        chk("rst_seq_r0", {24'd0, tx_data}, 32'h00000011);
        @(negedge clk);
        tx_ready = 1'b0;
        chk("rst_seq_r1",       {24'd0, tx_data},  32'h00000022);
        @(negedge clk);
        chk("rst_seq_stall",    {24'd0, tx_data},  32'h00000022);
        chk("rst_seq_valid",    {31'd0, tx_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midframe_reset");
        @(negedge clk);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset_idle");
        run_frame(32'h04030201, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_dump
